control_unit: RTL

- Hardwired control sequencer for the 32-bit datapath (Datapath2).
- Replaces bench-driven control: fetches, decodes IR[31:27] and asserts datapath control strobes across timing steps T0..T7.
- Sits beside the datapath. Consumes IR and the CON flag. Drives every register-enable, bus-select, memory and ALU-op line.

---
 rtl/control_unit_if.sv | 26 ++
 rtl/control_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Control-unit to datapath bundle: instruction/flag inputs and every control strobe.
// The control unit is the master; the datapath (or bench) is the slave.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON;
  logic        PCout, Zlowout, MDRout, BAout, Cout, Rout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin;
  logic        Gra, Grb, Grc;
  logic        Read, Write;
  logic [4:0]  ALU_Control;
  logic        Run;

  modport master (
    input  IR, CON,
    output PCout, Zlowout, MDRout, BAout, Cout, Rout,
    output PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin,
    output Gra, Grb, Grc, Read, Write, ALU_Control, Run
  );

  modport slave (
    output IR, CON,
    input  PCout, Zlowout, MDRout, BAout, Cout, Rout,
    input  PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin,
    input  Gra, Grb, Grc, Read, Write, ALU_Control, Run
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the 32-bit datapath.
// Strobes are a Moore decode of the step register and the live opcode.
module control_unit #(
  parameter logic [4:0] OP_INC = 5'd12,
  parameter logic [4:0] OP_ADD = 5'd2,
  parameter logic [4:0] OP_SUB = 5'd3,
  parameter logic [4:0] OP_AND = 5'd4,
  parameter logic [4:0] OP_OR  = 5'd5
) (
  input  logic           clk,
  input  logic           clr_n,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE, C_ITYPE, C_LD, C_ST, C_BR, C_JR, C_NOP, C_HALT
  } class_e;

  state_e     state_q, state_d;
  class_e     cls;
  logic [4:0] alu_op;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];

  // Unlisted opcodes fall through to nop.
  always_comb begin
    cls    = C_NOP;
    alu_op = 5'd0;
    case (opcode)
      5'd0:  cls = C_LD;
      5'd2:  cls = C_ST;
      5'd3:  begin cls = C_RTYPE; alu_op = OP_ADD; end
      5'd4:  begin cls = C_RTYPE; alu_op = OP_SUB; end
      5'd5:  begin cls = C_RTYPE; alu_op = OP_AND; end
      5'd6:  begin cls = C_RTYPE; alu_op = OP_OR;  end
      5'd12: begin cls = C_ITYPE; alu_op = OP_ADD; end
      5'd13: begin cls = C_ITYPE; alu_op = OP_AND; end
      5'd14: begin cls = C_ITYPE; alu_op = OP_OR;  end
      5'd18: cls = C_BR;
      5'd19: cls = C_JR;
      5'd27: cls = C_HALT;
      default: cls = C_NOP;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  state_d = S_T3;
      S_T3: begin
        case (cls)
          C_HALT:      state_d = S_HALT;
          C_JR, C_NOP: state_d = S_T0;
          default:     state_d = S_T4;
        endcase
      end
      S_T4:  state_d = S_T5;
      S_T5:  state_d = (cls == C_RTYPE || cls == C_ITYPE) ? S_T0 : S_T6;
      S_T6:  state_d = (cls == C_BR) ? S_T0 : S_T7;
      S_T7:  state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Reset clears state_q asynchronously, so every strobe drops without a clock.
  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0;
    bus.BAout = 1'b0; bus.Cout    = 1'b0; bus.Rout   = 1'b0;
    bus.PCin  = 1'b0; bus.MARin   = 1'b0; bus.MDRin  = 1'b0;
    bus.IRin  = 1'b0; bus.Yin     = 1'b0; bus.Zin    = 1'b0;
    bus.Rin   = 1'b0; bus.CONin   = 1'b0;
    bus.Gra   = 1'b0; bus.Grb     = 1'b0; bus.Grc    = 1'b0;
    bus.Read  = 1'b0; bus.Write   = 1'b0;
    bus.ALU_Control = 5'd0;
    bus.Run   = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.Zin = 1'b1;
        bus.ALU_Control = OP_INC;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_RTYPE, C_ITYPE: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
          C_LD, C_ST:       begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
          C_BR:             begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
          C_JR:             begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_RTYPE: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.ALU_Control = alu_op;
          end
          C_ITYPE: begin
            bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ALU_Control = alu_op;
          end
          C_LD, C_ST: begin
            bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ALU_Control = OP_ADD;
          end
          C_BR: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_RTYPE, C_ITYPE: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_LD, C_ST:       begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
          C_BR: begin
            bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ALU_Control = OP_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
          C_ST: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
          C_BR: begin bus.Zlowout = 1'b1; bus.PCin = bus.CON; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_ST: bus.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
